// File: rtl/link_pkg.sv
// Shared types and constants for the link transmit scheduler: tag type,
// FSM state encoding, fixed source indices and the round-robin wrap helper.
package link_pkg;

    localparam int TAG_W = 2;

    typedef logic [TAG_W-1:0] tag_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND     = 3'd1,
        WAIT_TX  = 3'd2,
        WAIT_ACK = 3'd3,
        DONE     = 3'd4,
        ERROR    = 3'd5
    } sched_state_t;

    localparam tag_t TAG_CTRL   = 2'd0;
    localparam tag_t TAG_PADDLE = 2'd1;
    localparam tag_t TAG_BALL   = 2'd2;
    localparam tag_t TAG_SCORE  = 2'd3;

    // Pointer after a grant to source k (k >= 1); index 0 never takes part in the rotation.
    function automatic int rr_next(input int k, input int num_req);
        return (k >= num_req - 1) ? 1 : k + 1;
    endfunction

endpackage

// File: rtl/link_tx_scheduler_rr_arbiter.sv
// Combinational arbiter: source 0 always wins, the rest rotate starting at rr_ptr
// and wrapping back to 1.
module rr_arbiter
    import link_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int TW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [TW-1:0]      rr_ptr,
    output logic [TW-1:0]      gnt,
    output logic               gnt_valid
);

    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        if (req[0]) begin
            gnt       = TW'(TAG_CTRL);
            gnt_valid = 1'b1;
        end else begin
            // Two passes give the wrap-around: first rr_ptr..top, then 1..rr_ptr-1.
            for (int j = 1; j < NUM_REQ; j++) begin
                if (!gnt_valid && req[j] && (TW'(j) >= rr_ptr)) begin
                    gnt       = TW'(j);
                    gnt_valid = 1'b1;
                end
            end
            for (int j = 1; j < NUM_REQ; j++) begin
                if (!gnt_valid && req[j] && (TW'(j) < rr_ptr)) begin
                    gnt       = TW'(j);
                    gnt_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/link_tx_scheduler.sv
// Shares the serial link sender among several message sources, waits for acks
// on acknowledged messages and retransmits on timeout until the link is declared dead.
module link_tx_scheduler
    import link_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int DATA_W      = 16,
    parameter  int ACK_TIMEOUT = 50000,
    parameter  int MAX_RETRY   = 3,
    localparam int TW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int RW          = $clog2(MAX_RETRY + 1),
    localparam int TMW         = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1
) (
    input  logic                      clock,
    input  logic                      reset_L,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        need_ack,
    output logic [NUM_REQ-1:0]        grant_done,
    output logic                      tx_valid,
    output logic [TW-1:0]             tx_tag,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_ready,
    input  logic                      tx_done,
    input  logic                      ack_rcvd,
    input  logic [TW-1:0]             ack_tag,
    output logic                      busy,
    output logic [RW-1:0]             retry_cnt,
    output logic                      link_error,
    output sched_state_t              state_dbg
);

    sched_state_t        state;
    logic [TW-1:0]       rr_ptr;
    logic [TW-1:0]       arb_gnt;
    logic                arb_valid;
    logic [DATA_W-1:0]   win_data;
    logic                win_need_ack;
    logic                need_ack_q;
    logic                ack_seen;
    logic                ack_match;
    logic                timeout_hit;
    logic [TMW-1:0]      timer;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .gnt       (arb_gnt),
        .gnt_valid (arb_valid)
    );

    always_comb begin
        win_data     = '0;
        win_need_ack = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt == TW'(i)) begin
                win_data     = req_data[i*DATA_W +: DATA_W];
                win_need_ack = need_ack[i];
            end
        end
    end

    assign ack_match   = ack_rcvd && (ack_tag == tx_tag);
    assign timeout_hit = (timer == TMW'(ACK_TIMEOUT - 1));

    // Handshake: tx_valid is high for the whole SEND state with tx_tag/tx_data held
    // stable; the frame transfers on the first edge where tx_valid && tx_ready, and
    // the FSM leaves SEND on that same edge.
    assign tx_valid  = (state == SEND);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_comb begin
        grant_done = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_done[i] = ((state == DONE) || (state == ERROR)) && (tx_tag == TW'(i));
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state      <= IDLE;
            rr_ptr     <= TW'(1);
            tx_tag     <= '0;
            tx_data    <= '0;
            need_ack_q <= 1'b0;
            ack_seen   <= 1'b0;
            timer      <= '0;
            retry_cnt  <= '0;
            link_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        tx_tag     <= arb_gnt;
                        tx_data    <= win_data;
                        need_ack_q <= win_need_ack;
                        ack_seen   <= 1'b0;
                        state      <= SEND;
                        if (arb_gnt != '0) begin
                            rr_ptr <= TW'(rr_next(int'(arb_gnt), NUM_REQ));
                        end
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        state <= WAIT_TX;
                    end
                end
                WAIT_TX: begin
                    // An ack can overtake the sender's own completion pulse.
                    if (ack_match) begin
                        ack_seen <= 1'b1;
                    end
                    if (tx_done) begin
                        if (!need_ack_q || ack_seen || ack_match) begin
                            state <= DONE;
                        end else begin
                            state <= WAIT_ACK;
                            timer <= '0;
                        end
                    end
                end
                WAIT_ACK: begin
                    timer <= timer + 1'b1;
                    if (ack_match) begin
                        state <= DONE;
                    end else if (timeout_hit) begin
                        if (retry_cnt < RW'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            ack_seen  <= 1'b0;
                            state     <= SEND;
                        end else begin
                            state <= ERROR;
                        end
                    end
                end
                DONE: begin
                    retry_cnt <= '0;
                    state     <= IDLE;
                end
                ERROR: begin
                    link_error <= 1'b1;
                    retry_cnt  <= '0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_link_tx_scheduler.sv
// Randomized self-checking bench for link_tx_scheduler with a short ack timeout.
module tb_link_tx_scheduler;
    import link_pkg::*;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int TO = 16;
    localparam int MR = 3;

    logic            clock = 1'b0;
    logic            reset_L = 1'b0;
    logic [NR-1:0]   req = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]   need_ack = '0;
    logic [NR-1:0]   grant_done;
    logic            tx_valid;
    logic [1:0]      tx_tag;
    logic [DW-1:0]   tx_data;
    logic            tx_ready = 1'b1;
    logic            tx_done = 1'b0;
    logic            ack_rcvd = 1'b0;
    logic [1:0]      ack_tag = '0;
    logic            busy;
    logic [1:0]      retry_cnt;
    logic            link_error;
    sched_state_t    state_dbg;

    int checks = 0;
    int failures = 0;
    int gd_pulses = 0;
    int m_ptr = 1;
    logic [DW-1:0] cur_data[NR];
    logic [1:0]    exp_q[$];

    link_tx_scheduler #(
        .NUM_REQ(NR), .DATA_W(DW), .ACK_TIMEOUT(TO), .MAX_RETRY(MR)
    ) dut (
        .clock(clock), .reset_L(reset_L), .req(req), .req_data(req_data),
        .need_ack(need_ack), .grant_done(grant_done), .tx_valid(tx_valid),
        .tx_tag(tx_tag), .tx_data(tx_data), .tx_ready(tx_ready), .tx_done(tx_done),
        .ack_rcvd(ack_rcvd), .ack_tag(ack_tag), .busy(busy), .retry_cnt(retry_cnt),
        .link_error(link_error), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (grant_done != '0) gd_pulses = gd_pulses + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_L  = 1'b0;
        req      = '0;
        need_ack = '0;
        tx_done  = 1'b0;
        ack_rcvd = 1'b0;
        tx_ready = 1'b1;
        repeat (2) tick();
        reset_L = 1'b1;
        m_ptr   = 1;
        exp_q.delete();
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] v);
        cur_data[i] = v;
        req_data[i*DW +: DW] = v;
    endtask

    // Sender emulation: waits for an offered frame, accepts it (optionally after
    // random stalls), then pulses tx_done done_delay cycles later.
    task automatic send_frame(input int done_delay, input bit stall, output bit ok,
                              output logic [1:0] tag, output logic [DW-1:0] data,
                              output bit stable);
        int n;
        n = 0;
        ok = 1'b0;
        stable = 1'b1;
        tag = '0;
        data = '0;
        while (tx_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (tx_valid !== 1'b1) return;
        tag = tx_tag;
        data = tx_data;
        n = 0;
        forever begin
            if (tx_valid !== 1'b1 || tx_tag !== tag || tx_data !== data) stable = 1'b0;
            tx_ready = (stall && n < 6) ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
            if (tx_ready) break;
        end
        tx_ready = 1'b1;
        repeat (done_delay) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        ok = 1'b1;
    endtask

    // Reference arbitration: control source first, otherwise the first requester
    // at or above the pointer among 1..NR-1, wrapping; pointer moves past the winner.
    function automatic int model_pick(input logic [NR-1:0] r);
        int k;
        if (r[0]) return 0;
        for (int s = 0; s < NR - 1; s++) begin
            k = ((m_ptr - 1 + s) % (NR - 1)) + 1;
            if (r[k]) begin
                m_ptr = (k == NR - 1) ? 1 : k + 1;
                return k;
            end
        end
        return -1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_L = 1'b0;
        tick();
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid: got %0b exp 0", tx_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b exp 0", busy); end
        checks++; if (grant_done !== 4'b0) begin failures++; $display("FAIL reset_grant_done: got %b exp 0000", grant_done); end
        checks++; if (retry_cnt !== 2'd0) begin failures++; $display("FAIL reset_retry_cnt: got %0d exp 0", retry_cnt); end
        checks++; if (link_error !== 1'b0) begin failures++; $display("FAIL reset_link_error: got %0b exp 0", link_error); end
        checks++; if (tx_tag !== 2'd0 || tx_data !== 16'h0) begin failures++; $display("FAIL reset_tx_payload: got tag %0d data %h exp 0/0000", tx_tag, tx_data); end
        checks++; if (state_dbg !== IDLE) begin failures++; $display("FAIL reset_state: got %0d exp %0d", state_dbg, IDLE); end
        reset_L = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        set_data(1, 16'h00A5);
        need_ack = 4'b0000;
        req = 4'b0010;
        tick();
        checks++; if (tx_valid !== 1'b1 || tx_tag !== TAG_PADDLE || tx_data !== 16'h00A5) begin
            failures++; $display("FAIL single_offer: got valid %0b tag %0d data %h exp 1/1/00a5", tx_valid, tx_tag, tx_data); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %0b exp 1", busy); end
        tick();
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL single_valid_drop: got %0b exp 0", tx_valid); end
        repeat (19) tick();
        checks++; if (grant_done !== 4'b0000) begin failures++; $display("FAIL single_early_grant: got %b exp 0000", grant_done); end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checks++; if (grant_done !== 4'b0010) begin failures++; $display("FAIL single_grant_done: got %b exp 0010", grant_done); end
        req = 4'b0000;
        tick();
        checks++; if (grant_done !== 4'b0000 || busy !== 1'b0) begin
            failures++; $display("FAIL single_idle: got grant %b busy %0b exp 0000/0", grant_done, busy); end
    endtask

    task automatic test_arbitration();
        logic [NR-1:0] pending;
        logic [1:0] tag;
        logic [DW-1:0] data;
        logic [1:0] exp_tag;
        bit ok, stable;
        int w;
        do_reset();
        need_ack = '0;
        for (int i = 0; i < NR; i++) set_data(i, 16'($urandom));
        pending = 4'b1111;
        for (int m = 0; m < 20; m++) begin
            if (m == 4) pending = 4'b1111;
            else if (m >= 8) pending = pending | 4'($urandom_range(0, 15));
            if (m >= 12 && m < 16) pending[0] = 1'b1;
            if (pending == '0) pending = 4'b0010;
            req = pending;
            w = model_pick(pending);
            exp_q.push_back(2'(w));
            send_frame($urandom_range(1, 5), 1'b1, ok, tag, data, stable);
            exp_tag = exp_q.pop_front();
            checks++; if (!ok) begin failures++; $display("FAIL arb_timeout msg %0d: no tx_valid within bound", m); end
            checks++; if (tag !== exp_tag) begin failures++; $display("FAIL arb_order msg %0d: got tag %0d exp %0d", m, tag, exp_tag); end
            checks++; if (data !== cur_data[w]) begin failures++; $display("FAIL arb_data msg %0d: got %h exp %h", m, data, cur_data[w]); end
            checks++; if (!stable) begin failures++; $display("FAIL arb_stable msg %0d: tag/data/valid changed while stalled", m); end
            checks++; if (grant_done !== 4'(1 << w)) begin failures++; $display("FAIL arb_grant msg %0d: got %b exp %b", m, grant_done, 4'(1 << w)); end
            pending[w] = 1'b0;
            set_data(w, 16'($urandom));
        end
        req = '0;
        tick();
    endtask

    task automatic test_ack();
        logic [1:0] tag;
        logic [DW-1:0] data;
        bit ok, stable, quiet;
        int d;
        do_reset();
        set_data(2, 16'($urandom));
        need_ack = 4'b0100;
        req = 4'b0100;
        tick();
        // Matching ack while still in SEND must be ignored.
        tx_ready = 1'b0;
        ack_rcvd = 1'b1;
        ack_tag  = 2'd2;
        tick();
        ack_rcvd = 1'b0;
        send_frame($urandom_range(1, 5), 1'b0, ok, tag, data, stable);
        checks++; if (!ok || tag !== TAG_BALL) begin failures++; $display("FAIL ack_offer: got ok %0b tag %0d exp 1/2", ok, tag); end
        checks++; if (grant_done !== 4'b0000 || busy !== 1'b1) begin
            failures++; $display("FAIL ack_waiting: got grant %b busy %0b exp 0000/1", grant_done, busy); end
        d = $urandom_range(3, 12);
        quiet = 1'b1;
        for (int c = 0; c < d; c++) begin
            ack_rcvd = (c == 1);
            ack_tag  = 2'd3;
            tick();
            ack_rcvd = 1'b0;
            if (grant_done !== 4'b0000 || tx_valid !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet) begin failures++; $display("FAIL ack_wrong_tag: got early grant/resend exp none"); end
        ack_rcvd = 1'b1;
        ack_tag  = 2'd2;
        tick();
        ack_rcvd = 1'b0;
        checks++; if (grant_done !== 4'b0100) begin failures++; $display("FAIL ack_grant: got %b exp 0100", grant_done); end
        checks++; if (retry_cnt !== 2'd0 || link_error !== 1'b0) begin
            failures++; $display("FAIL ack_status: got retry %0d err %0b exp 0/0", retry_cnt, link_error); end
        req = '0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ack_idle: got busy %0b exp 0", busy); end
    endtask

    task automatic test_retry_error();
        logic [1:0] tag;
        logic [DW-1:0] data, orig;
        bit ok, stable;
        int gap, hs, gd0;
        do_reset();
        orig = 16'($urandom);
        set_data(3, orig);
        need_ack = 4'b1000;
        req = 4'b1000;
        hs = 0;
        gd0 = gd_pulses;
        for (int a = 0; a <= MR; a++) begin
            send_frame($urandom_range(1, 4), 1'b1, ok, tag, data, stable);
            if (ok) hs++;
            checks++; if (tag !== TAG_SCORE || data !== orig || !stable) begin
                failures++; $display("FAIL retx_payload try %0d: got tag %0d data %h stable %0b exp 3/%h/1", a, tag, data, stable, orig); end
            set_data(3, 16'($urandom));
            gap = 0;
            while (tx_valid !== 1'b1 && grant_done === 4'b0000 && gap < 100) begin
                ack_rcvd = (a == 0 && gap == 2);
                ack_tag  = 2'd0;
                tick();
                ack_rcvd = 1'b0;
                gap++;
            end
            checks++; if (gap != TO) begin failures++; $display("FAIL retry_gap try %0d: got %0d cycles exp %0d", a, gap, TO); end
            if (a < MR) begin
                checks++; if (tx_valid !== 1'b1 || grant_done !== 4'b0000) begin
                    failures++; $display("FAIL retry_resend try %0d: got valid %0b grant %b exp 1/0000", a, tx_valid, grant_done); end
                checks++; if (retry_cnt !== 2'(a + 1)) begin failures++; $display("FAIL retry_cnt try %0d: got %0d exp %0d", a, retry_cnt, a + 1); end
            end else begin
                checks++; if (grant_done !== 4'b1000 || tx_valid !== 1'b0) begin
                    failures++; $display("FAIL error_grant: got grant %b valid %0b exp 1000/0", grant_done, tx_valid); end
            end
        end
        req = '0;
        tick();
        checks++; if (link_error !== 1'b1 || busy !== 1'b0 || retry_cnt !== 2'd0) begin
            failures++; $display("FAIL error_state: got err %0b busy %0b retry %0d exp 1/0/0", link_error, busy, retry_cnt); end
        checks++; if (hs != MR + 1) begin failures++; $display("FAIL error_handshakes: got %0d exp %0d", hs, MR + 1); end
        repeat (3) tick();
        checks++; if (gd_pulses - gd0 != 1) begin failures++; $display("FAIL error_pulses: got %0d exp 1", gd_pulses - gd0); end
        // Arbitration keeps working after an error and the flag stays set.
        need_ack = '0;
        set_data(1, 16'h1234);
        req = 4'b0010;
        send_frame(2, 1'b0, ok, tag, data, stable);
        checks++; if (grant_done !== 4'b0010 || link_error !== 1'b1) begin
            failures++; $display("FAIL error_after: got grant %b err %0b exp 0010/1", grant_done, link_error); end
        req = '0;
        tick();
    endtask

    task automatic test_edges();
        logic [1:0] tag;
        logic [DW-1:0] data;
        bit ok, stable;
        int n, gd0;
        do_reset();
        checks++; if (link_error !== 1'b0) begin failures++; $display("FAIL edge_err_cleared: got %0b exp 0", link_error); end
        // Ack on the very cycle the timeout expires.
        set_data(1, 16'($urandom));
        need_ack = 4'b0010;
        req = 4'b0010;
        send_frame($urandom_range(1, 4), 1'b0, ok, tag, data, stable);
        repeat (TO - 1) tick();
        ack_rcvd = 1'b1;
        ack_tag  = 2'd1;
        tick();
        ack_rcvd = 1'b0;
        checks++; if (grant_done !== 4'b0010 || tx_valid !== 1'b0) begin
            failures++; $display("FAIL edge_ack_timeout: got grant %b valid %0b exp 0010/0", grant_done, tx_valid); end
        checks++; if (retry_cnt !== 2'd0) begin failures++; $display("FAIL edge_ack_timeout_retry: got %0d exp 0", retry_cnt); end
        req = '0;
        tick();
        // Ack overtaking tx_done.
        set_data(2, 16'($urandom));
        need_ack = 4'b0100;
        req = 4'b0100;
        n = 0;
        while (tx_valid !== 1'b1 && n < 50) begin tick(); n++; end
        checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL edge_early_offer: no tx_valid within bound"); end
        tick();
        ack_rcvd = 1'b1;
        ack_tag  = 2'd2;
        tick();
        ack_rcvd = 1'b0;
        repeat (3) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checks++; if (grant_done !== 4'b0100) begin failures++; $display("FAIL edge_early_ack: got %b exp 0100", grant_done); end
        req = '0;
        tick();
        // Asynchronous reset while waiting for an ack after one retry.
        set_data(3, 16'($urandom));
        need_ack = 4'b1000;
        req = 4'b1000;
        send_frame(2, 1'b0, ok, tag, data, stable);
        repeat (TO) tick();
        checks++; if (retry_cnt !== 2'd1 || tx_valid !== 1'b1) begin
            failures++; $display("FAIL edge_pre_reset: got retry %0d valid %0b exp 1/1", retry_cnt, tx_valid); end
        send_frame(2, 1'b0, ok, tag, data, stable);
        repeat (2) tick();
        gd0 = gd_pulses;
        #2;
        reset_L = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || tx_valid !== 1'b0 || grant_done !== 4'b0000 || retry_cnt !== 2'd0 || state_dbg !== IDLE) begin
            failures++; $display("FAIL edge_async_reset: got busy %0b valid %0b grant %b retry %0d exp 0/0/0000/0", busy, tx_valid, grant_done, retry_cnt); end
        req = '0;
        need_ack = '0;
        tick();
        reset_L = 1'b1;
        repeat (5) tick();
        checks++; if (gd_pulses != gd0 || busy !== 1'b0) begin
            failures++; $display("FAIL edge_no_grant_after_reset: got pulses %0d busy %0b exp 0/0", gd_pulses - gd0, busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_ack();
        test_retry_error();
        test_edges();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/link_tx_scheduler.md
Name: link_tx_scheduler

Overview:
- Shares one serial message sender on each board among several message sources: ack/control, paddle update, ball sync and score.
- Picks a winner and presents its tagged payload to the sender with a valid/ready handshake.
- For acknowledged messages, waits for the matching ack from the receiver and retransmits on timeout.
- Sits between the game state machine / paddle logic and the link sender/receiver inside ChipInterface.

Parameters:
- NUM_REQ, 4, number of requesters; index 0 is the strict-priority control source.
- DATA_W, 16, payload width per message.
- ACK_TIMEOUT, 50000, clock cycles to wait for an ack before retransmitting.
- MAX_RETRY, 3, retransmissions allowed after the first send before the link is declared dead.

Ports:
- clock  input  1  system clock.
- reset_L  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-source request level; held until the matching grant_done.
- req_data  input  NUM_REQ*DATA_W  packed payloads; source i occupies bits [i*DATA_W +: DATA_W].
- need_ack  input  NUM_REQ  per-source flag; sampled at grant.
- grant_done  output  NUM_REQ  one-cycle pulse: source's message delivered, or abandoned on error.
- tx_valid  output  1  frame offered to the sender.
- tx_tag  output  $clog2(NUM_REQ)  source index of the offered frame.
- tx_data  output  DATA_W  latched payload.
- tx_ready  input  1  sender idle; the frame is accepted on a cycle where tx_valid and tx_ready are both 1.
- tx_done  input  1  one-cycle pulse: sender finished shifting the frame.
- ack_rcvd  input  1  one-cycle pulse from the receiver.
- ack_tag  input  $clog2(NUM_REQ)  tag carried by the ack.
- busy  output  1  FSM not in IDLE.
- retry_cnt  output  $clog2(MAX_RETRY+1)  retries used on the current message.
- link_error  output  1  sticky; cleared only by reset.

Behaviour:
Reset (asynchronous, reset_L = 0):
- State IDLE; tx_valid, busy, grant_done, retry_cnt, link_error all 0.
- tx_data and tx_tag 0; round-robin pointer rr_ptr = 1.

States and transitions:
- IDLE: if any req bit is set, select a winner in this same cycle and latch its tag, data and need_ack. Go to SEND; busy = 1 from the next cycle.
- Arbitration: req[0] always wins. Otherwise round-robin over indices 1..NUM_REQ-1, searching upward from rr_ptr with wrap-around. After a grant to index k >= 1, rr_ptr = k+1, wrapping to 1 past NUM_REQ-1. A grant to index 0 leaves rr_ptr unchanged.
- SEND: tx_valid = 1 with tag/data stable until tx_ready = 1 (handshake). Next state WAIT_TX; tx_valid drops the following cycle.
- WAIT_TX: on tx_done, go to DONE if need_ack = 0 or an ack was already seen. Otherwise go to WAIT_ACK with the timer cleared.
- WAIT_ACK: the timer increments each cycle.
  - On ack_rcvd with ack_tag == latched tag: go to DONE.
  - On timer == ACK_TIMEOUT-1 with retry_cnt < MAX_RETRY: increment retry_cnt, go to SEND with the same tag and data.
  - On timer == ACK_TIMEOUT-1 with retry_cnt == MAX_RETRY: go to ERROR.
- DONE: pulse grant_done[tag] for 1 cycle, clear retry_cnt, return to IDLE. A new arbitration may happen on the next cycle.
- ERROR: set link_error, pulse grant_done[tag], clear retry_cnt, return to IDLE. Arbitration continues normally after an error.

Boundary conditions:
- A matching ack arriving in WAIT_TX is recorded in an ack_seen flag (cleared on each SEND entry).
- An ack arriving in the same cycle as the timeout wins.
- Acks with a mismatched tag, or arriving in IDLE or SEND, are ignored.
- A req deasserted mid-flight does not cancel the message; grant_done still pulses.
- Payload changes after grant are ignored; retransmissions reuse the latched data.
- Latency: req to tx_valid is 1 cycle from IDLE. Minimum req to grant_done without ack is tx_done + 1 cycle.
- Reset mid-operation aborts the message immediately, with no grant_done pulse.

Decomposition:
- Shared package link_pkg holds:
  - typedef tag_t for the tag width;
  - enum sched_state_t {IDLE, SEND, WAIT_TX, WAIT_ACK, DONE, ERROR};
  - localparams for the source indices TAG_CTRL = 0, TAG_PADDLE = 1, TAG_BALL = 2, TAG_SCORE = 3.
- One sub-module, rr_arbiter: combinational round-robin with the priority-0 override. Takes req and rr_ptr; returns a grant index and a valid flag.

Test Plan:
- Single source, no ack: req = 0010, data 0x00A5, need_ack = 0; tx_ready = 1 → tx_valid the cycle after req with tag 1 and data 0x00A5. tx_done after 20 cycles → grant_done = 0010 one cycle later; busy returns to 0.
- Arbitration: req = 1111 held, no ack, tx_done 5 cycles after each accept → grant order 0,1,2,3,0,1,2,3 …. Holding req[0] continuously while others request → 0 is granted after every message.
- Ack path: tag 2 with need_ack = 1 → an ack with ack_tag = 2 arriving 100 cycles after tx_done gives DONE with grant_done[2]. An ack with tag 3 is ignored and the timer keeps running.
- Retry and error: ACK_TIMEOUT = 16, MAX_RETRY = 3, no acks → 4 total tx_valid handshakes, each 16 cycles after the previous tx_done. retry_cnt steps 1, 2, 3; link_error = 1 and grant_done pulses once.
- Edge conditions:
  - An ack coincident with the final timeout cycle → DONE and no retry.
  - An ack during WAIT_TX → DONE right after tx_done.
  - reset_L pulled low in WAIT_ACK → all outputs 0 asynchronously and no grant_done pulse.
